vga_fifo_fill_ctrl: RTL and testbench

Fetch sequencer that keeps the VGA pixel FIFO (`vga_fifo`) supplied with frame data. It runs Wishbone incrementing-burst reads from video memory and writes the returned words into the FIFO's write port. It clears the FIFO at each frame start and throttles fetches on the FIFO's half-full flag. It sits between the Wishbone master port and the FIFO; the pixel generator owns the FIFO read side.

---
 rtl/vga_fifo_fill_ctrl_if.sv | 34 +++
 rtl/vga_fifo_fill_ctrl.sv | 168 ++++++++++++++++
 tb/tb_vga_fifo_fill_ctrl.sv | 502 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fifo_fill_ctrl_if.sv
// Wishbone burst-read bus between the VGA fetch
// sequencer (master) and video memory (slave).
interface vga_fifo_fill_ctrl_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_adr_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic [31:0] wb_dat_i;

  modport master (
    output wb_cyc_o,
    output wb_stb_o,
    output wb_adr_o,
    output wb_cti_o,
    output wb_bte_o,
    input  wb_ack_i,
    input  wb_err_i,
    input  wb_dat_i
  );

  modport slave (
    input  wb_cyc_o,
    input  wb_stb_o,
    input  wb_adr_o,
    input  wb_cti_o,
    input  wb_bte_o,
    output wb_ack_i,
    output wb_err_i,
    output wb_dat_i
  );
endinterface

// File: rtl/vga_fifo_fill_ctrl.sv
// VGA pixel FIFO fill sequencer: Wishbone burst
// reads of frame memory into the FIFO write port.
module vga_fifo_fill_ctrl #(
  parameter int AWIDTH = 7,
  parameter int BURST  = 8
) (
  input  logic                clk,
  input  logic                aclr,
  input  logic                ctrl_en,
  input  logic                frame_start,
  input  logic [31:0]         vbase,
  input  logic [23:0]         vsize,
  input  logic                fifo_hfull,
  output logic                fifo_sclr,
  output logic                fifo_wreq,
  output logic [31:0]         fifo_d,
  vga_fifo_fill_ctrl_if.master wb,
  output logic                busy,
  output logic                err
);

  localparam int BW   = $clog2(BURST + 1);
  localparam int HALF = 2 ** (AWIDTH - 1);

  // A burst must fit in the FIFO headroom above half-full.
  if (BURST < 1 || BURST > HALF - 1) begin : g_bad_burst
    $error("BURST outside 1 .. 2^(AWIDTH-1)-1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT,
    S_BURST,
    S_ERROR
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [29:0]     addr;
  logic [29:0]     addr_n;
  logic [23:0]     remain;
  logic [23:0]     remain_n;
  logic [BW-1:0]   beats;
  logic [BW-1:0]   beats_n;
  logic            pend;
  logic            pend_n;
  logic            err_n;
  logic            wr_n;
  logic            fs_en;
  logic            unused_ok;

  assign fs_en     = frame_start & ctrl_en;
  assign unused_ok = ^vbase[1:0];
  assign wb.wb_bte_o = 2'b00;

  // State register.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state, counters and write strobe.
  always_comb begin
    state_n  = state;
    addr_n   = addr;
    remain_n = remain;
    beats_n  = beats;
    pend_n   = pend;
    err_n    = err;
    wr_n     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fs_en) state_n = S_CLEAR;
      end
      S_CLEAR: begin
        addr_n   = vbase[31:2];
        remain_n = vsize;
        err_n    = 1'b0;
        pend_n   = 1'b0;
        state_n  = (vsize == 24'd0) ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (!ctrl_en) begin
          state_n = S_IDLE;
        end else if (frame_start) begin
          state_n = S_CLEAR;
        end else if (!fifo_hfull) begin
          state_n = S_BURST;
          if (remain < 24'(BURST)) beats_n = BW'(remain);
          else                     beats_n = BW'(BURST);
        end
      end
      S_BURST: begin
        if (fs_en) pend_n = 1'b1;
        if (wb.wb_err_i) begin
          err_n   = 1'b1;
          pend_n  = 1'b0;
          state_n = S_ERROR;
        end else if (wb.wb_ack_i) begin
          addr_n   = addr + 30'd1;
          remain_n = remain - 24'd1;
          beats_n  = beats - BW'(1);
          wr_n     = 1'b1;
          if (beats == BW'(1)) begin
            pend_n = 1'b0;
            if (pend || fs_en)
              state_n = S_CLEAR;
            else if (!ctrl_en || remain_n == 24'd0)
              state_n = S_IDLE;
            else
              state_n = S_WAIT;
          end
        end
      end
      S_ERROR: begin
        if (fs_en) state_n = S_CLEAR;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Fetch address, remaining words, burst beats.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      addr   <= '0;
      remain <= '0;
      beats  <= '0;
      pend   <= 1'b0;
    end else begin
      addr   <= addr_n;
      remain <= remain_n;
      beats  <= beats_n;
      pend   <= pend_n;
    end
  end

  // Registered bus, FIFO and status outputs.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      wb.wb_cyc_o <= 1'b0;
      wb.wb_stb_o <= 1'b0;
      wb.wb_adr_o <= '0;
      wb.wb_cti_o <= 3'b000;
      fifo_sclr   <= 1'b0;
      fifo_wreq   <= 1'b0;
      fifo_d      <= '0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      wb.wb_cyc_o <= (state_n == S_BURST);
      wb.wb_stb_o <= (state_n == S_BURST);
      wb.wb_adr_o <= {addr_n, 2'b00};
      if (state_n != S_BURST)
        wb.wb_cti_o <= 3'b000;
      else if (beats_n == BW'(1))
        wb.wb_cti_o <= 3'b111;
      else
        wb.wb_cti_o <= 3'b010;
      fifo_sclr <= (state_n == S_CLEAR);
      fifo_wreq <= wr_n;
      if (wr_n) fifo_d <= wb.wb_dat_i;
      busy <= (state_n != S_IDLE) && (state_n != S_ERROR);
      err  <= err_n;
    end
  end

endmodule

// File: tb/tb_vga_fifo_fill_ctrl.sv
// Bench for vga_fifo_fill_ctrl: memory slave, bus
// monitor and a word-list reference of each frame.
module tb_vga_fifo_fill_ctrl;

  localparam int BURST = 8;

  logic        clk = 1'b0;
  logic        aclr = 1'b0;
  logic        ctrl_en = 1'b0;
  logic        frame_start = 1'b0;
  logic [31:0] vbase = '0;
  logic [23:0] vsize = '0;
  logic        fifo_hfull = 1'b0;
  logic        fifo_sclr;
  logic        fifo_wreq;
  logic [31:0] fifo_d;
  logic        busy;
  logic        err;

  logic        ack_en = 1'b1;
  logic        err_armed = 1'b0;
  int          err_at = 0;
  int          acks_done = 0;
  logic        err_inj;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mon_adr[$];
  logic [2:0]  mon_cti[$];
  logic [31:0] mon_wr[$];
  int          n_sclr = 0;
  int          n_bursts = 0;
  int          n_cyc_hi = 0;
  logic        cyc_q = 1'b0;

  logic [31:0] exp_adr[$];
  logic [2:0]  exp_cti[$];

  vga_fifo_fill_ctrl_if bus();

  vga_fifo_fill_ctrl #(.AWIDTH(7), .BURST(BURST)) dut (
    .clk         (clk),
    .aclr        (aclr),
    .ctrl_en     (ctrl_en),
    .frame_start (frame_start),
    .vbase       (vbase),
    .vsize       (vsize),
    .fifo_hfull  (fifo_hfull),
    .fifo_sclr   (fifo_sclr),
    .fifo_wreq   (fifo_wreq),
    .fifo_d      (fifo_d),
    .wb          (bus),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign err_inj = err_armed && (acks_done == err_at);
  assign bus.wb_ack_i = bus.wb_cyc_o & bus.wb_stb_o
                      & ack_en & ~err_inj;
  assign bus.wb_err_i = bus.wb_cyc_o & bus.wb_stb_o
                      & err_inj;
  assign bus.wb_dat_i = mem(bus.wb_adr_o);

  always @(posedge clk or negedge aclr) begin
    if (!aclr) acks_done <= 0;
    else if (bus.wb_cyc_o && bus.wb_ack_i)
      acks_done <= acks_done + 1;
  end

  always @(negedge clk) begin
    if (bus.wb_cyc_o && bus.wb_ack_i) begin
      mon_adr.push_back(bus.wb_adr_o);
      mon_cti.push_back(bus.wb_cti_o);
    end
    if (fifo_wreq) mon_wr.push_back(fifo_d);
    if (fifo_sclr) n_sclr <= n_sclr + 1;
    if (bus.wb_cyc_o && !cyc_q) n_bursts <= n_bursts + 1;
    if (bus.wb_cyc_o) n_cyc_hi <= n_cyc_hi + 1;
    cyc_q <= bus.wb_cyc_o;
  end

  // Frame of vs words from vb: consecutive words,
  // chopped into BURST-sized bursts from the start.
  function automatic void model_frame(
    input logic [31:0] vb, input int vs);
    logic [31:0] a0;
    a0 = {vb[31:2], 2'b00};
    for (int i = 0; i < vs; i++) begin
      exp_adr.push_back(a0 + 32'(4 * i));
      if ((i % BURST) == BURST - 1 || i == vs - 1)
        exp_cti.push_back(3'b111);
      else
        exp_cti.push_back(3'b010);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input int lim, input bit rnd,
                           output bit to);
    to = 1'b1;
    for (int i = 0; i < lim; i++) begin
      if (!busy) begin
        to = 1'b0;
        break;
      end
      if (rnd) begin
        ack_en = ($urandom_range(0, 9) < 7);
        fifo_hfull = ($urandom_range(0, 9) < 3);
      end
      tick();
    end
    ack_en = 1'b1;
    fifo_hfull = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    aclr = 1'b0;
    ctrl_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      frame_start = i[0];
      tick();
      n_chk++;
      if ({fifo_sclr, fifo_wreq, fifo_d, busy, err,
           bus.wb_cyc_o, bus.wb_stb_o, bus.wb_adr_o,
           bus.wb_cti_o, bus.wb_bte_o} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc %0d: got nonzero outputs, want 0", i);
      end
    end
    frame_start = 1'b0;
    aclr = 1'b1;
    repeat (3) tick();
    n_chk++;
    if (bus.wb_cyc_o !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: cyc=%b busy=%b want 0 0",
               bus.wb_cyc_o, busy);
    end
  endtask

  task automatic test_full_frame();
    int ba, bw, bb, bh;
    bit to;
    ba = mon_adr.size(); bw = mon_wr.size();
    bb = n_bursts; bh = n_cyc_hi;
    exp_adr.delete(); exp_cti.delete();
    vbase = 32'h0000_1000; vsize = 24'd20;
    model_frame(vbase, 20);
    pulse_fs();
    n_chk++;
    if (fifo_sclr !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ff_clear: sclr=%b busy=%b want 1 1",
               fifo_sclr, busy);
    end
    tick();
    n_chk++;
    if (fifo_sclr !== 1'b0 || bus.wb_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ff_wait: sclr=%b cyc=%b want 0 0",
               fifo_sclr, bus.wb_cyc_o);
    end
    tick();
    n_chk++;
    if (bus.wb_cyc_o !== 1'b1 || bus.wb_stb_o !== 1'b1 ||
        bus.wb_adr_o !== 32'h1000 ||
        bus.wb_cti_o !== 3'b010 || bus.wb_bte_o !== 2'b00) begin
      n_fail++;
      $display("FAIL ff_first_beat: cyc=%b stb=%b adr=%h cti=%b want 1 1 1000 010",
               bus.wb_cyc_o, bus.wb_stb_o, bus.wb_adr_o,
               bus.wb_cti_o);
    end
    wait_idle(300, 1'b0, to);
    n_chk++;
    if (to) begin
      n_fail++;
      $display("FAIL ff_timeout: busy stuck, want idle");
    end
    n_chk++;
    if (n_bursts - bb !== 3 || n_cyc_hi - bh !== 20) begin
      n_fail++;
      $display("FAIL ff_bursts: bursts=%0d cyc_cycles=%0d want 3 20",
               n_bursts - bb, n_cyc_hi - bh);
    end
    n_chk++;
    if (mon_adr.size() - ba !== 20 ||
        mon_wr.size() - bw !== 20) begin
      n_fail++;
      $display("FAIL ff_count: beats=%0d writes=%0d want 20 20",
               mon_adr.size() - ba, mon_wr.size() - bw);
    end else begin
      for (int i = 0; i < 20; i++) begin
        n_chk++;
        if (mon_adr[ba+i] !== exp_adr[i] ||
            mon_cti[ba+i] !== exp_cti[i] ||
            mon_wr[bw+i] !== mem(exp_adr[i])) begin
          n_fail++;
          $display("FAIL ff_beat %0d: adr=%h cti=%b d=%h want %h %b %h",
                   i, mon_adr[ba+i], mon_cti[ba+i],
                   mon_wr[bw+i], exp_adr[i], exp_cti[i],
                   mem(exp_adr[i]));
        end
      end
    end
    n_chk++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL ff_done: busy=%b err=%b want 0 0",
               busy, err);
    end
  endtask

  task automatic test_random_frames();
    int ba, bw, bb, vs, nb;
    bit to;
    for (int f = 0; f < 8; f++) begin
      ba = mon_adr.size(); bw = mon_wr.size();
      bb = n_bursts;
      exp_adr.delete(); exp_cti.delete();
      if (f == 0) begin
        vbase = 32'hFFFF_FFF3; vs = 10;
      end else begin
        vbase = $urandom; vs = $urandom_range(1, 40);
      end
      vsize = 24'(vs);
      model_frame(vbase, vs);
      nb = (vs + BURST - 1) / BURST;
      pulse_fs();
      wait_idle(2000, 1'b1, to);
      n_chk++;
      if (to || n_bursts - bb !== nb) begin
        n_fail++;
        $display("FAIL rnd_bursts f%0d: to=%b bursts=%0d want 0 %0d",
                 f, to, n_bursts - bb, nb);
      end
      n_chk++;
      if (mon_adr.size() - ba !== vs ||
          mon_wr.size() - bw !== vs) begin
        n_fail++;
        $display("FAIL rnd_count f%0d: beats=%0d writes=%0d want %0d",
                 f, mon_adr.size() - ba,
                 mon_wr.size() - bw, vs);
      end else begin
        for (int i = 0; i < vs; i++) begin
          n_chk++;
          if (mon_adr[ba+i] !== exp_adr[i] ||
              mon_cti[ba+i] !== exp_cti[i] ||
              mon_wr[bw+i] !== mem(exp_adr[i])) begin
            n_fail++;
            $display("FAIL rnd_beat f%0d/%0d: adr=%h cti=%b d=%h want %h %b %h",
                     f, i, mon_adr[ba+i], mon_cti[ba+i],
                     mon_wr[bw+i], exp_adr[i], exp_cti[i],
                     mem(exp_adr[i]));
          end
        end
      end
    end
  endtask

  task automatic test_throttle();
    int bh, bw;
    bit to;
    bw = mon_wr.size();
    vbase = 32'h0000_4000; vsize = 24'd8;
    fifo_hfull = 1'b1;
    pulse_fs();
    tick();
    bh = n_cyc_hi;
    repeat (50) tick();
    n_chk++;
    if (n_cyc_hi - bh !== 0 || bus.wb_cyc_o !== 1'b0 ||
        busy !== 1'b1) begin
      n_fail++;
      $display("FAIL thr_hold: cyc_cycles=%0d busy=%b want 0 1",
               n_cyc_hi - bh, busy);
    end
    fifo_hfull = 1'b0;
    n_chk++;
    if (bus.wb_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL thr_drop_same: cyc=%b want 0",
               bus.wb_cyc_o);
    end
    tick();
    n_chk++;
    if (bus.wb_cyc_o !== 1'b1 ||
        bus.wb_adr_o !== 32'h4000) begin
      n_fail++;
      $display("FAIL thr_release: cyc=%b adr=%h want 1 4000",
               bus.wb_cyc_o, bus.wb_adr_o);
    end
    wait_idle(200, 1'b0, to);
    n_chk++;
    if (to || mon_wr.size() - bw !== 8) begin
      n_fail++;
      $display("FAIL thr_writes: to=%b writes=%0d want 0 8",
               to, mon_wr.size() - bw);
    end
  endtask

  task automatic test_restart();
    int ba, bw, bb, bs, a0, n;
    bit to;
    ba = mon_adr.size(); bw = mon_wr.size();
    bb = n_bursts;
    exp_adr.delete(); exp_cti.delete();
    vbase = 32'h0000_2000; vsize = 24'd20;
    model_frame(vbase, 8);
    model_frame(vbase, 20);
    a0 = acks_done;
    pulse_fs();
    for (int i = 0; i < 30; i++) begin
      if (acks_done - a0 >= 2) break;
      tick();
    end
    bs = n_sclr;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_idle(400, 1'b0, to);
    n_chk++;
    if (to || n_sclr - bs !== 1 || n_bursts - bb !== 4) begin
      n_fail++;
      $display("FAIL rs_seq: to=%b sclr=%0d bursts=%0d want 0 1 4",
               to, n_sclr - bs, n_bursts - bb);
    end
    n = exp_adr.size();
    n_chk++;
    if (mon_adr.size() - ba !== n ||
        mon_wr.size() - bw !== n) begin
      n_fail++;
      $display("FAIL rs_count: beats=%0d writes=%0d want %0d",
               mon_adr.size() - ba, mon_wr.size() - bw, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        n_chk++;
        if (mon_adr[ba+i] !== exp_adr[i] ||
            mon_cti[ba+i] !== exp_cti[i] ||
            mon_wr[bw+i] !== mem(exp_adr[i])) begin
          n_fail++;
          $display("FAIL rs_beat %0d: adr=%h cti=%b want %h %b",
                   i, mon_adr[ba+i], mon_cti[ba+i],
                   exp_adr[i], exp_cti[i]);
        end
      end
    end
  endtask

  task automatic test_bus_error();
    int bw, bb;
    bit to;
    bw = mon_wr.size(); bb = n_bursts;
    vbase = 32'h0000_3000; vsize = 24'd20;
    err_at = acks_done + 2;
    err_armed = 1'b1;
    pulse_fs();
    for (int i = 0; i < 50; i++) begin
      if (err) break;
      tick();
    end
    n_chk++;
    if (err !== 1'b1 || bus.wb_cyc_o !== 1'b0 ||
        busy !== 1'b0) begin
      n_fail++;
      $display("FAIL be_stop: err=%b cyc=%b busy=%b want 1 0 0",
               err, bus.wb_cyc_o, busy);
    end
    repeat (30) tick();
    n_chk++;
    if (mon_wr.size() - bw !== 2 || n_bursts - bb !== 1 ||
        err !== 1'b1) begin
      n_fail++;
      $display("FAIL be_quiet: writes=%0d bursts=%0d err=%b want 2 1 1",
               mon_wr.size() - bw, n_bursts - bb, err);
    end else begin
      n_chk++;
      if (mon_wr[bw] !== mem(32'h3000) ||
          mon_wr[bw+1] !== mem(32'h3004)) begin
        n_fail++;
        $display("FAIL be_data: %h %h want %h %h",
                 mon_wr[bw], mon_wr[bw+1],
                 mem(32'h3000), mem(32'h3004));
      end
    end
    err_armed = 1'b0;
    bw = mon_wr.size();
    pulse_fs();
    tick();
    n_chk++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL be_clear: err=%b want 0", err);
    end
    wait_idle(300, 1'b0, to);
    n_chk++;
    if (to || mon_wr.size() - bw !== 20 ||
        mon_wr[bw+19] !== mem(32'h304C)) begin
      n_fail++;
      $display("FAIL be_refetch: to=%b writes=%0d want 0 20",
               to, mon_wr.size() - bw);
    end
  endtask

  task automatic test_vsize_zero();
    int bs, bb;
    bs = n_sclr; bb = n_bursts;
    vbase = 32'h0000_5000; vsize = 24'd0;
    pulse_fs();
    n_chk++;
    if (fifo_sclr !== 1'b1) begin
      n_fail++;
      $display("FAIL vz_sclr: sclr=%b want 1", fifo_sclr);
    end
    repeat (20) tick();
    n_chk++;
    if (n_sclr - bs !== 1 || n_bursts - bb !== 0 ||
        busy !== 1'b0) begin
      n_fail++;
      $display("FAIL vz_quiet: sclr=%0d bursts=%0d busy=%b want 1 0 0",
               n_sclr - bs, n_bursts - bb, busy);
    end
  endtask

  task automatic test_aclr_mid_burst();
    int a0, bw;
    bit to;
    vbase = 32'h0000_6000; vsize = 24'd20;
    a0 = acks_done;
    pulse_fs();
    for (int i = 0; i < 30; i++) begin
      if (acks_done - a0 >= 2) break;
      tick();
    end
    n_chk++;
    if (bus.wb_cyc_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_pre: cyc=%b want 1", bus.wb_cyc_o);
    end
    aclr = 1'b0;
    #1;
    n_chk++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_adr_o,
         bus.wb_cti_o, busy, fifo_wreq} !== '0) begin
      n_fail++;
      $display("FAIL ar_drop: cyc=%b adr=%h busy=%b want all 0",
               bus.wb_cyc_o, bus.wb_adr_o, busy);
    end
    tick();
    aclr = 1'b1;
    repeat (5) tick();
    n_chk++;
    if (bus.wb_cyc_o !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_idle: cyc=%b busy=%b want 0 0",
               bus.wb_cyc_o, busy);
    end
    bw = mon_wr.size();
    vsize = 24'd3;
    pulse_fs();
    wait_idle(100, 1'b0, to);
    n_chk++;
    if (to || mon_wr.size() - bw !== 3) begin
      n_fail++;
      $display("FAIL ar_resume: to=%b writes=%0d want 0 3",
               to, mon_wr.size() - bw);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_random_frames();
    test_throttle();
    test_restart();
    test_bus_error();
    test_vsize_zero();
    test_aclr_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
